// File: rtl/pc_fetch_unit_if.sv
// Bundle of the IF-stage signals: redirect input, hazard stall, imem handshake, IF/ID outputs
// and performance counters. The slave modport is the fetch unit; the master is its environment.
interface pc_fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             pc_sel;
  logic [31:0]      branch_target;
  logic             hold;
  logic             imem_busywait;
  logic [31:0]      instr_in;
  logic             imem_read;
  logic [31:0]      imem_addr;
  logic [31:0]      ifid_pc;
  logic [31:0]      ifid_instr;
  logic             ifid_valid;
  logic             flush;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output pc_sel, branch_target, hold, imem_busywait, instr_in,
    input  imem_read, imem_addr, ifid_pc, ifid_instr, ifid_valid, flush,
           redirect_cnt, bubble_cnt
  );

  modport slave (
    input  pc_sel, branch_target, hold, imem_busywait, instr_in,
    output imem_read, imem_addr, ifid_pc, ifid_instr, ifid_valid, flush,
           redirect_cnt, bubble_cnt
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage PC sequencer and IF/ID register with redirect, drain of wrong-path imem accesses and stalls.
// Optional saturating redirect/bubble counters are enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  pc_fetch_unit_if.slave  bus_if
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;

  logic [31:0] target_d;
  logic        bubble_load_d;
  logic        flush_d;
  logic        unused_target_lsbs;

  assign target_d           = {bus_if.branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^bus_if.branch_target[1:0];
  assign flush_d            = bus_if.pc_sel & (state_q != IDLE);

  // Edges that load a bubble into IF/ID; HOLD outranks a busy imem in FETCH.
  always_comb begin
    bubble_load_d = 1'b0;
    case (state_q)
      FETCH:   bubble_load_d = bus_if.pc_sel | (~bus_if.hold & bus_if.imem_busywait);
      DRAIN:   bubble_load_d = 1'b1;
      default: bubble_load_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
        end
        FETCH: begin
          if (bus_if.pc_sel) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
            if (bus_if.imem_busywait) begin
              pend_pc_q <= target_d;
              state_q   <= DRAIN;
            end else begin
              pc_q <= target_d;
            end
          end else if (bus_if.hold) begin
            pc_q <= pc_q;
          end else if (bus_if.imem_busywait) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
          end else begin
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= bus_if.instr_in;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_q + 32'd4;
          end
        end
        DRAIN: begin
          // The in-flight access belongs to the wrong path: its data is dropped.
          ifid_valid_q <= 1'b0;
          ifid_instr_q <= NOP;
          if (bus_if.pc_sel) begin
            pend_pc_q <= target_d;
          end
          if (!bus_if.imem_busywait) begin
            pc_q    <= bus_if.pc_sel ? target_d : pend_pc_q;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.imem_addr  = pc_q;
  assign bus_if.imem_read  = (state_q != IDLE);
  assign bus_if.flush      = flush_d;
  assign bus_if.ifid_pc    = ifid_pc_q;
  assign bus_if.ifid_instr = ifid_instr_q;
  assign bus_if.ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      redirect_cnt_q <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      if (flush_d && (redirect_cnt_q != {CNT_W{1'b1}})) begin
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      end
      if (bubble_load_d && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
    end
  end

  assign bus_if.redirect_cnt = redirect_cnt_q;
  assign bus_if.bubble_cnt   = bubble_cnt_q;
`else
  logic unused_bubble_load;
  assign unused_bubble_load  = bubble_load_d;
  assign bus_if.redirect_cnt = {CNT_W{1'b0}};
  assign bus_if.bubble_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven check of pc_fetch_unit: per-cycle imem/flush outputs plus a scoreboard of IF/ID contents.
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        pc_sel;
    logic [31:0] tgt;
    logic        hold;
    logic        busy;
    logic [31:0] instr;
    logic [31:0] e_addr;
    logic        e_read;
    logic        e_flush;
    logic [31:0] e_ifpc;
    logic [31:0] e_ifinstr;
    logic        e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        valid;
  } ifid_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  vec_t  vecs[29];
  ifid_t exp_q[$];

  pc_fetch_unit_if #(.CNT_W(32)) bus_if ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ps, input logic [31:0] t, input logic h,
                              input logic b, input logic [31:0] ins, input logic [31:0] ea,
                              input logic er, input logic ef, input logic [31:0] epc,
                              input logic [31:0] eins, input logic ev);
    vec_t v;
    v.rst = r; v.pc_sel = ps; v.tgt = t; v.hold = h; v.busy = b; v.instr = ins;
    v.e_addr = ea; v.e_read = er; v.e_flush = ef; v.e_ifpc = epc; v.e_ifinstr = eins; v.e_valid = ev;
    return v;
  endfunction

  task automatic check_counters(input logic [31:0] e_redir, input logic [31:0] e_bub);
`ifdef FETCH_PERF_CNT_EN
    chk("redirect_cnt", bus_if.redirect_cnt, e_redir);
    chk("bubble_cnt", bus_if.bubble_cnt, e_bub);
`else
    chk("redirect_cnt", bus_if.redirect_cnt, 32'h0 & e_redir);
    chk("bubble_cnt", bus_if.bubble_cnt, 32'h0 & e_bub);
`endif
  endtask

  initial begin
    ifid_t got;
    //             rst ps tgt           hold busy instr          addr         rd fl ifid_pc       ifid_instr    v
    vecs[0]  = mk(0, 1, 32'h500,      0, 0, 32'hD000_0000, 32'h0,        0, 0, 32'h0,        NOP,          0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'hD000_0001, 32'h0,        1, 0, 32'h0,        32'hD000_0001, 1);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'hD000_0002, 32'h4,        1, 0, 32'h4,        32'hD000_0002, 1);
    vecs[3]  = mk(0, 1, 32'h103,      0, 0, 32'hD000_0003, 32'h8,        1, 1, 32'h4,        NOP,          0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'hD000_0004, 32'h100,      1, 0, 32'h100,      32'hD000_0004, 1);
    vecs[5]  = mk(0, 1, 32'h12,       0, 0, 32'hD000_0005, 32'h104,      1, 1, 32'h100,      NOP,          0);
    vecs[6]  = mk(0, 1, 32'h40,       0, 1, 32'hD000_0006, 32'h10,       1, 1, 32'h100,      NOP,          0);
    vecs[7]  = mk(0, 0, 32'h0,        1, 1, 32'hD000_0007, 32'h10,       1, 0, 32'h100,      NOP,          0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 1, 32'hD000_0008, 32'h10,       1, 0, 32'h100,      NOP,          0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'hD000_0009, 32'h10,       1, 0, 32'h100,      NOP,          0);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'hD000_000A, 32'h40,       1, 0, 32'h40,       32'hD000_000A, 1);
    vecs[11] = mk(0, 1, 32'h20,       0, 0, 32'hD000_000B, 32'h44,       1, 1, 32'h40,       NOP,          0);
    vecs[12] = mk(0, 0, 32'h0,        0, 0, 32'hD000_000C, 32'h20,       1, 0, 32'h20,       32'hD000_000C, 1);
    vecs[13] = mk(0, 0, 32'h0,        1, 0, 32'hD000_000D, 32'h24,       1, 0, 32'h20,       32'hD000_000C, 1);
    vecs[14] = mk(0, 0, 32'h0,        1, 0, 32'hD000_000E, 32'h24,       1, 0, 32'h20,       32'hD000_000C, 1);
    vecs[15] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'hD000_000F, 32'h24,      1, 1, 32'h20,       NOP,          0);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 32'hD000_00E0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 32'hD000_00E0, 1);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 32'hD000_00E1, 32'h0,        1, 0, 32'h0,        32'hD000_00E1, 1);
    vecs[18] = mk(0, 0, 32'h0,        0, 1, 32'hD000_00E2, 32'h4,        1, 0, 32'h0,        NOP,          0);
    vecs[19] = mk(0, 0, 32'h0,        1, 1, 32'hD000_00E3, 32'h4,        1, 0, 32'h0,        NOP,          0);
    vecs[20] = mk(0, 0, 32'h0,        0, 0, 32'hD000_00E4, 32'h4,        1, 0, 32'h4,        32'hD000_00E4, 1);
    vecs[21] = mk(0, 1, 32'h200,      0, 1, 32'hD000_00E5, 32'h8,        1, 1, 32'h4,        NOP,          0);
    vecs[22] = mk(0, 1, 32'h300,      0, 1, 32'hD000_00E6, 32'h8,        1, 1, 32'h4,        NOP,          0);
    vecs[23] = mk(1, 1, 32'h400,      0, 0, 32'hD000_00E7, 32'h8,        1, 1, 32'h0,        NOP,          0);
    vecs[24] = mk(0, 0, 32'h0,        0, 0, 32'hD000_00E8, 32'h0,        0, 0, 32'h0,        NOP,          0);
    vecs[25] = mk(0, 0, 32'h0,        0, 0, 32'hD000_00E9, 32'h0,        1, 0, 32'h0,        32'hD000_00E9, 1);
    vecs[26] = mk(0, 1, 32'h80,       0, 1, 32'hD000_00EA, 32'h4,        1, 1, 32'h0,        NOP,          0);
    vecs[27] = mk(0, 1, 32'h90,       0, 0, 32'hD000_00EB, 32'h4,        1, 1, 32'h0,        NOP,          0);
    vecs[28] = mk(0, 0, 32'h0,        0, 0, 32'hD000_00EC, 32'h90,       1, 0, 32'h90,       32'hD000_00EC, 1);

    bus_if.pc_sel = 1'b0; bus_if.branch_target = 32'h0; bus_if.hold = 1'b0;
    bus_if.imem_busywait = 1'b0; bus_if.instr_in = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ifid_pc", bus_if.ifid_pc, 32'h0);
    chk("reset ifid_instr", bus_if.ifid_instr, NOP);
    chk("reset ifid_valid", {31'h0, bus_if.ifid_valid}, 32'h0);
    check_counters(32'h0, 32'h0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst                  = vecs[i].rst;
      bus_if.pc_sel        = vecs[i].pc_sel;
      bus_if.branch_target = vecs[i].tgt;
      bus_if.hold          = vecs[i].hold;
      bus_if.imem_busywait = vecs[i].busy;
      bus_if.instr_in      = vecs[i].instr;
      #1;
      chk($sformatf("v%0d imem_addr", i), bus_if.imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d imem_read", i), {31'h0, bus_if.imem_read}, {31'h0, vecs[i].e_read});
      chk($sformatf("v%0d flush", i), {31'h0, bus_if.flush}, {31'h0, vecs[i].e_flush});
      exp_q.push_back('{vecs[i].e_ifpc, vecs[i].e_ifinstr, vecs[i].e_valid});
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk($sformatf("v%0d ifid_pc", i), bus_if.ifid_pc, got.ifpc);
      chk($sformatf("v%0d ifid_instr", i), bus_if.ifid_instr, got.ifinstr);
      chk($sformatf("v%0d ifid_valid", i), {31'h0, bus_if.ifid_valid}, {31'h0, got.valid});
      $display("vec %0d: addr=%h flush=%0b ifid_pc=%h ifid_instr=%h valid=%0b",
               i, vecs[i].e_addr, vecs[i].e_flush, bus_if.ifid_pc, bus_if.ifid_instr, bus_if.ifid_valid);
      if (i == 22) check_counters(32'd7, 32'd11);
    end
    check_counters(32'd2, 32'd2);

    // Hand sequence: sequential fetch straight out of reset.
    @(negedge clk);
    rst = 1'b1; bus_if.pc_sel = 1'b0; bus_if.hold = 1'b0; bus_if.imem_busywait = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] e_addr;
      e_addr = (k < 2) ? 32'h0 : 32'(k - 1) * 32'd4;
      bus_if.instr_in = 32'hA000_0000 + 32'(k);
      #1;
      chk($sformatf("seq%0d imem_addr", k), bus_if.imem_addr, e_addr);
      if (k >= 1) begin
        exp_q.push_back('{e_addr, 32'hA000_0000 + 32'(k), 1'b1});
      end else begin
        exp_q.push_back('{32'h0, NOP, 1'b0});
      end
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk($sformatf("seq%0d ifid_pc", k), bus_if.ifid_pc, got.ifpc);
      chk($sformatf("seq%0d ifid_valid", k), {31'h0, bus_if.ifid_valid}, {31'h0, got.valid});
      $display("seq %0d: addr=%h ifid_pc=%h valid=%0b", k, e_addr, bus_if.ifid_pc, bus_if.ifid_valid);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
